// File: rtl/lut_sweep_pkg.sv
// Shared types and constants for the LUT sweep evaluator.
package lut_sweep_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // Reset truth table for the 3-input build: minterms 0, 4 and 5.
    localparam logic [7:0] DEFAULT_TABLE_N3 = 8'h31;

endpackage

// File: rtl/lut_out_stage.sv
// Single-entry valid/ready output register: load when free, hold under back-pressure, clear on drain.
module lut_out_stage #(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [N_IN-1:0] load_vec,
    input  logic            load_y,
    input  logic            out_ready,
    output logic            out_free,
    output logic            out_valid,
    output logic [N_IN-1:0] out_vec,
    output logic            out_y
);

    logic            valid_d, valid_q;
    logic [N_IN-1:0] vec_d, vec_q;
    logic            y_d, y_q;

    assign out_free  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_vec   = vec_q;
    assign out_y     = y_q;

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        valid_d = valid_q;
        vec_d   = vec_q;
        y_d     = y_q;
        if (load) begin
            valid_d = 1'b1;
            vec_d   = load_vec;
            y_d     = load_y;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            valid_q <= 1'b0;
            vec_q   <= '0;
            y_q     <= 1'b0;
        end else begin
            valid_q <= valid_d;
            vec_q   <= vec_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: rtl/lut_sweep_eval.sv
// Runtime-loadable N-input boolean function unit with a valid/ready output
// stream and an exhaustive sweep mode that counts the function's minterms.
module lut_sweep_eval
    import lut_sweep_pkg::*;
#(
    parameter int                 N_IN          = 3,
    parameter logic [2**N_IN-1:0] DEFAULT_TABLE = DEFAULT_TABLE_N3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [2**N_IN-1:0]   cfg_table,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN-1:0]      in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_y,
    output logic [N_IN-1:0]      out_vec,
    input  logic                 sweep_start,
    output logic                 sweep_busy,
    output logic                 sweep_done,
    output logic [N_IN:0]        minterm_count
);

    localparam int TBL_W = 2**N_IN;
    localparam int CW    = N_IN + 1;

    state_t           state_d, state_q;
    logic [TBL_W-1:0] tbl_d, tbl_q;
    logic [CW-1:0]    ctr_d, ctr_q;
    logic [CW-1:0]    acc_d, acc_q;
    logic [CW-1:0]    minterm_d, minterm_q;
    logic             done_d, done_q;

    logic             load;
    logic [N_IN-1:0]  load_vec;
    logic             load_y;
    logic             out_free;
    logic [N_IN-1:0]  sweep_idx;

    assign sweep_idx     = ctr_q[N_IN-1:0];
    assign sweep_busy    = (state_q == SWEEP);
    assign sweep_done    = done_q;
    assign minterm_count = minterm_q;

    always_comb begin
        state_d   = state_q;
        tbl_d     = tbl_q;
        ctr_d     = ctr_q;
        acc_d     = acc_q;
        minterm_d = minterm_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        load      = 1'b0;
        load_vec  = in_vec;
        load_y    = tbl_q[in_vec];

        case (state_q)
            IDLE: begin
                in_ready = out_free && !sweep_start;
                // Reads above use tbl_q, so a same-cycle write only affects later vectors.
                if (cfg_we) tbl_d = cfg_table;
                if (sweep_start) begin
                    state_d = SWEEP;
                    ctr_d   = '0;
                    acc_d   = '0;
                end else if (in_valid && out_free) begin
                    load = 1'b1;
                end
            end
            SWEEP: begin
                // ctr is one bit wider than the vector so reaching TBL_W means "all loaded".
                if (ctr_q != CW'(TBL_W)) begin
                    if (out_free) begin
                        load     = 1'b1;
                        load_vec = sweep_idx;
                        load_y   = tbl_q[sweep_idx];
                        acc_d    = acc_q + CW'(tbl_q[sweep_idx]);
                        ctr_d    = ctr_q + CW'(1);
                    end
                end else if (out_valid && out_ready) begin
                    minterm_d = acc_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            // NOTE: the truth table is a plain flop vector, not a RAM, so it takes a defined reset value.
            tbl_q     <= DEFAULT_TABLE;
            ctr_q     <= '0;
            acc_q     <= '0;
            minterm_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tbl_q     <= tbl_d;
            ctr_q     <= ctr_d;
            acc_q     <= acc_d;
            minterm_q <= minterm_d;
            done_q    <= done_d;
        end
    end

    lut_out_stage #(.N_IN(N_IN)) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_vec  (load_vec),
        .load_y    (load_y),
        .out_ready (out_ready),
        .out_free  (out_free),
        .out_valid (out_valid),
        .out_vec   (out_vec),
        .out_y     (out_y)
    );

endmodule

// File: tb/tb_lut_sweep_eval.sv
// Scoreboard bench for lut_sweep_eval: a 3-input instance for the main
// scenarios and a 1-input instance for the smallest legal configuration.
module tb_lut_sweep_eval;

    typedef struct {
        logic [7:0] vec;
        logic       y;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_table = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_vec = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_y;
    logic [2:0] out_vec;
    logic       sweep_start = 1'b0;
    logic       sweep_busy;
    logic       sweep_done;
    logic [3:0] minterm_count;

    logic       s1_cfg_we = 1'b0;
    logic [1:0] s1_cfg_table = '0;
    logic       s1_in_valid = 1'b0;
    logic       s1_in_ready;
    logic [0:0] s1_in_vec = '0;
    logic       s1_out_valid;
    logic       s1_out_ready = 1'b1;
    logic       s1_out_y;
    logic [0:0] s1_out_vec;
    logic       s1_sweep_start = 1'b0;
    logic       s1_sweep_busy;
    logic       s1_sweep_done;
    logic [1:0] s1_minterm;

    lut_sweep_eval dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_table(cfg_table),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_vec(out_vec),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .minterm_count(minterm_count)
    );

    lut_sweep_eval #(.N_IN(1), .DEFAULT_TABLE(2'b10)) dut1 (
        .clk(clk), .reset(reset), .cfg_we(s1_cfg_we), .cfg_table(s1_cfg_table),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_vec(s1_in_vec),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_y(s1_out_y), .out_vec(s1_out_vec),
        .sweep_start(s1_sweep_start), .sweep_busy(s1_sweep_busy), .sweep_done(s1_sweep_done),
        .minterm_count(s1_minterm)
    );

    int         n_checks = 0;
    int         n_pass = 0;
    int         done3 = 0;
    int         done1 = 0;
    logic [7:0] model_tbl = 8'h31;
    beat_t      q3[$];
    beat_t      q1[$];
    beat_t      e3;
    beat_t      e1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop the scoreboard on every accepted output beat.
    always @(negedge clk) begin
        if (!reset) begin
            if (sweep_done) done3++;
            if (out_valid && out_ready) begin
                if (q3.size() == 0) begin
                    fail_event($sformatf("unexpected_beat3 vec=%0d y=%0d", out_vec, out_y));
                end else begin
                    e3 = q3.pop_front();
                    check("beat3_vec", 32'(out_vec), 32'(e3.vec));
                    check("beat3_y", 32'(out_y), 32'(e3.y));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (s1_sweep_done) done1++;
            if (s1_out_valid && s1_out_ready) begin
                if (q1.size() == 0) begin
                    fail_event($sformatf("unexpected_beat1 vec=%0d y=%0d", s1_out_vec, s1_out_y));
                end else begin
                    e1 = q1.pop_front();
                    check("beat1_vec", 32'(s1_out_vec), 32'(e1.vec));
                    check("beat1_y", 32'(s1_out_y), 32'(e1.y));
                end
            end
        end
    end

    // Present one vector until accepted; the expected beat is queued on acceptance.
    task automatic drive3(input logic [2:0] v, input logic exp_y);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_vec   = v;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                q3.push_back('{vec: 8'(v), y: exp_y});
            end
            step();
        end
        in_valid = 1'b0;
        if (!acc) fail_event($sformatf("drive3_timeout vec=%0d", v));
    endtask

    task automatic load_table3(input logic [7:0] t);
        cfg_we    = 1'b1;
        cfg_table = t;
        step();
        cfg_we    = 1'b0;
        model_tbl = t;
    endtask

    task automatic start_sweep3();
        sweep_start = 1'b1;
        for (int i = 0; i < 8; i++) q3.push_back('{vec: 8'(i), y: model_tbl[i]});
        step();
        sweep_start = 1'b0;
    endtask

    task automatic wait_done3(input int base, input string name);
        for (int i = 0; i < 200 && done3 == base; i++) step();
        if (done3 == base) fail_event($sformatf("%s sweep_done never seen", name));
    endtask

    // Expected f for the reset table 8'h31, vectors 0..7.
    logic exp_default [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int base;
        bit found;

        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sweep_busy", 32'(sweep_busy), 0);
        check("rst_sweep_done", 32'(sweep_done), 0);
        check("rst_minterm", 32'(minterm_count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        step();

        // 1: back-to-back evaluation with the reset table, one-cycle latency.
        for (int v = 0; v < 8; v++) begin
            drive3(3'(v), exp_default[v]);
            check("lat_out_valid", 32'(out_valid), 1);
            check("lat_out_vec", 32'(out_vec), 32'(v));
        end
        step();

        // 2: back-pressure holds the output and blocks input.
        out_ready = 1'b0;
        drive3(3'd3, 1'b0);
        in_valid = 1'b1;
        in_vec   = 3'd6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_out_vec", 32'(out_vec), 3);
            check("stall_out_y", 32'(out_y), 0);
            step();
        end
        out_ready = 1'b1;
        drive3(3'd6, 1'b0);
        step();
        step();

        // 3: all-ones table, free-running sweep.
        load_table3(8'hFF);
        base = done3;
        start_sweep3();
        @(negedge clk);
        check("sweep3_busy", 32'(sweep_busy), 1);
        check("sweep3_in_ready", 32'(in_ready), 0);
        wait_done3(base, "sweep_ff");
        step();
        step();
        step();
        check("sweep_ff_done_once", 32'(done3 - base), 1);
        check("sweep_ff_minterms", 32'(minterm_count), 8);
        check("sweep_ff_busy_after", 32'(sweep_busy), 0);

        // 4: reset table, toggling back-pressure, ignored mid-sweep config write.
        load_table3(8'h31);
        base = done3;
        start_sweep3();
        for (int i = 0; i < 200 && done3 == base; i++) begin
            out_ready = ~out_ready;
            cfg_we    = (i == 5);
            cfg_table = 8'h00;
            step();
        end
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        if (done3 == base) fail_event("sweep_toggle sweep_done never seen");
        step();
        check("sweep_toggle_minterms", 32'(minterm_count), 3);
        drive3(3'd0, 1'b1);
        step();

        // 5: sweep_start beats in_valid; then reset aborts the sweep.
        load_table3(8'h0F);
        base = done3;
        sweep_start = 1'b1;
        in_valid    = 1'b1;
        in_vec      = 3'd5;
        for (int i = 0; i < 8; i++) q3.push_back('{vec: 8'(i), y: model_tbl[i]});
        @(negedge clk);
        check("start_blocks_in_ready", 32'(in_ready), 0);
        step();
        sweep_start = 1'b0;
        in_valid    = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_vec == 3'd4) found = 1'b1;
            else step();
        end
        if (!found) fail_event("abort vector 4 never presented");
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        q3.delete();
        model_tbl = 8'h31;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_minterm", 32'(minterm_count), 0);
        check("abort_busy", 32'(sweep_busy), 0);
        check("abort_no_done", 32'(done3 - base), 0);
        step();
        drive3(3'd5, 1'b1);
        drive3(3'd3, 1'b0);
        step();
        step();

        // 6: single-input instance with table 2'b10.
        s1_in_valid = 1'b1;
        s1_in_vec   = 1'b0;
        @(negedge clk);
        check("n1_in_ready0", 32'(s1_in_ready), 1);
        if (s1_in_ready) q1.push_back('{vec: 8'd0, y: 1'b0});
        step();
        s1_in_vec = 1'b1;
        @(negedge clk);
        check("n1_in_ready1", 32'(s1_in_ready), 1);
        if (s1_in_ready) q1.push_back('{vec: 8'd1, y: 1'b1});
        step();
        s1_in_valid = 1'b0;
        step();
        base = done1;
        s1_sweep_start = 1'b1;
        q1.push_back('{vec: 8'd0, y: 1'b0});
        q1.push_back('{vec: 8'd1, y: 1'b1});
        step();
        s1_sweep_start = 1'b0;
        for (int i = 0; i < 50 && done1 == base; i++) step();
        if (done1 == base) fail_event("n1 sweep_done never seen");
        step();
        check("n1_minterms", 32'(s1_minterm), 1);
        check("n1_busy_after", 32'(s1_sweep_busy), 0);

        step();
        step();
        check("q3_drained", 32'(q3.size()), 0);
        check("q1_drained", 32'(q1.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lut_sweep_eval.md
Name: lut_sweep_eval

Overview:
Parametrised N-input boolean function evaluator with a runtime-loadable truth table, a registered valid/ready output stream and a built-in exhaustive sweep mode. The sweep applies every input vector 0..2^N_IN-1 and counts the minterms. It succeeds hard-wired sum-of-products blocks. Lab designs use it as a programmable function unit and self-checking stimulus source.

Parameters:
N_IN, 3, number of function inputs (1..8); input vector bit N_IN-1 is the MSB ("a").
DEFAULT_TABLE, 8'h31, reset truth table, width 2**N_IN; bit i = f(vector i). 8'h31 = minterms 0, 4, 5.
(localparam) TBL_W = 2**N_IN.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
cfg_we  in  1  load cfg_table into the truth-table register
cfg_table  in  TBL_W  new truth table
in_valid  in  1  in_vec valid
in_ready  out  1  block accepts in_vec this cycle
in_vec  in  N_IN  input vector to evaluate
out_valid  out  1  out_y/out_vec valid
out_ready  in  1  consumer accepts output
out_y  out  1  f(out_vec)
out_vec  out  N_IN  vector that produced out_y
sweep_start  in  1  begin exhaustive sweep (IDLE only)
sweep_busy  out  1  high while in SWEEP
sweep_done  out  1  one-cycle pulse when the last sweep beat is accepted
minterm_count  out  N_IN+1  number of vectors with f=1, from the last completed sweep

Behaviour:
- Reset (synchronous): table<=DEFAULT_TABLE, state<=IDLE, out_valid<=0, out_y<=0, out_vec<=0, sweep ctr<=0, acc<=0, minterm_count<=0, sweep_done<=0. Reset wins over all other inputs.
- Mid-sweep reset aborts the sweep. minterm_count is not updated and returns to 0.
- Output register stage: out_free = !out_valid || out_ready. Output is stable while out_valid && !out_ready.
- States: IDLE, SWEEP.
- IDLE:
  - in_ready = out_free && !sweep_start.
  - When in_valid && in_ready: next cycle out_vec<=in_vec, out_y<=table[in_vec], out_valid<=1. Latency is 1 cycle.
  - If out_ready && !accept: out_valid<=0.
- Config:
  - cfg_we is honoured only in IDLE. It is ignored in SWEEP.
  - The table write takes effect for vectors accepted in the cycle after the write.
  - A vector accepted in the same cycle as cfg_we uses the old table.
- Sweep start: sweep_start in IDLE moves to SWEEP with ctr<=0 and acc<=0. Priority: sweep_start beats in_valid in the same cycle (in_ready=0). Any pending output beat still drains normally.
- SWEEP:
  - in_ready=0, sweep_busy=1.
  - Each cycle out_free: load out_vec<=ctr, out_y<=table[ctr], out_valid<=1, acc<=acc+table[ctr], ctr<=ctr+1.
  - Back-pressure stalls ctr. No vector is skipped or repeated.
  - After vector TBL_W-1 is loaded, stop generating and wait until that beat is accepted (out_valid && out_ready).
  - On acceptance: minterm_count<=acc, sweep_done pulses for 1 cycle, state<=IDLE.
- sweep_start is ignored in SWEEP.
- Arithmetic widths:
  - ctr is N_IN+1 bits, so the terminal compare is against TBL_W with no wrap ambiguity.
  - acc and minterm_count are N_IN+1 bits; all-ones table gives TBL_W, which must not overflow.
- Throughput: 1 beat/cycle with out_ready held high. A full sweep with out_ready=1 takes TBL_W cycles from the first loaded beat to done.

Decomposition:
- Package lut_sweep_pkg holds state_t enum (IDLE, SWEEP) and the DEFAULT_TABLE constant for N_IN=3.
- One natural sub-module: lut_out_stage, the valid/ready output register (load, hold, clear). It is reused by both the IDLE and SWEEP paths.

Test Plan:
1. Reset, then eval vectors 000..111 one per cycle, out_ready=1 -> out_y = 1,0,0,0,1,1,0,0, each 1 cycle after accept, out_vec echoes the input.
2. Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_vec/out_y stable. Release -> next vector accepted, nothing lost or duplicated.
3. cfg_we with table 8'hFF, then sweep with out_ready=1 -> out_vec 0..7 in order, all out_y=1, sweep_done pulses once, minterm_count=8, sweep_busy low afterwards.
4. Default table, sweep with out_ready toggling 1/0 each cycle -> out_vec sequence 0..7 with no gaps, minterm_count=3, cfg_we issued mid-sweep has no effect.
5. sweep_start and in_valid asserted in the same cycle -> in_ready=0 and the input is not consumed. Then assert reset at vector 4 -> out_valid=0, table=8'h31, minterm_count=0.
6. N_IN=1, DEFAULT_TABLE=2'b10 -> eval 0->0 and 1->1. Sweep -> minterm_count=1.
